bcd_conv_scheduler: RTL and testbench

//  Time-shares one combinational 0..59 binary-to-BCD converter among NUM_CH

---
 rtl/bcd_conv_scheduler.sv | 151 +++++++++++++++
 tb/tb_bcd_conv_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one external 0..59 binary-to-BCD converter among NUM_CH channels.
// Optional macro BCD_RANGE_CHECK_EN: out-of-range grants (>59) raise err instead of updating digits.
module bcd_conv_scheduler #(
  parameter int NUM_CH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH*6-1:0]   bin_in,
  output logic [5:0]            conv_bin,
  input  logic [3:0]            conv_tens,
  input  logic [3:0]            conv_ones,
  output logic [NUM_CH-1:0]     ack,
  output logic [NUM_CH*8-1:0]   bcd_out,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_gnt;
  logic [IW-1:0]       w_grant;
  logic                w_grant_valid;
  logic                w_take;
  logic [NUM_CH-1:0]   w_eligible;
  logic [NUM_CH-1:0]   r_ack;
  logic [NUM_CH-1:0]   w_ack_next;
  logic [5:0]          r_conv_bin;
  logic [5:0]          w_sel_bin;
  logic                r_err;
  logic                w_sel_bad;
  logic                w_skip;
  logic                w_conv;
  logic                w_capture;

  // The channel acked this cycle is masked so a still-held req cannot be granted twice.
  assign w_eligible = req & ~r_ack;

  // Search ptr+1, ptr+2, ... ; iterate farthest-first so the nearest hit wins.
  always_comb begin
    logic [IW-1:0] idx;
    w_grant_valid = 1'b0;
    w_grant       = '0;
    idx           = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = IW'((int'(r_ptr) + k) % NUM_CH);
      if (w_eligible[idx]) begin
        w_grant_valid = 1'b1;
        w_grant       = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_conv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_valid) begin
          w_take       = 1'b1;
          w_state_next = S_CONV;
        end
      end
      S_CONV: begin
        w_conv       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_sel_bin = bin_in[int'(w_grant)*6 +: 6];

`ifdef BCD_RANGE_CHECK_EN
  logic r_range_err;
  assign w_sel_bad = (w_sel_bin > 6'd59);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_range_err <= 1'b0;
    end else if (w_take) begin
      r_range_err <= w_sel_bad;
    end
  end
  assign w_skip = r_range_err;
`else
  assign w_sel_bad = 1'b0;
  assign w_skip    = 1'b0;
`endif

  assign w_capture = w_conv & ~w_skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= IW'(NUM_CH - 1);
      r_gnt      <= '0;
      r_conv_bin <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ack <= w_ack_next;
      r_err <= w_conv & w_skip;
      if (w_take) begin
        r_gnt <= w_grant;
        r_ptr <= w_grant;
        // A rejected out-of-range value never reaches the converter.
        if (!w_sel_bad) begin
          r_conv_bin <= w_sel_bin;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [7:0] r_bcd;

    assign w_ack_next[gi] = w_conv & (r_gnt == IW'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_bcd <= 8'h00;
      end else if (w_capture && (r_gnt == IW'(gi))) begin
        r_bcd <= {conv_tens, conv_ones};
      end
    end

    assign bcd_out[gi*8 +: 8] = r_bcd;
  end

  assign conv_bin = r_conv_bin;
  assign ack      = r_ack;
  assign busy     = (r_state == S_CONV);
  assign err      = r_err;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Self-checking bench for bcd_conv_scheduler: vector table, directed corner sequences, randomized run vs. a transaction model.
module tb_bcd_conv_scheduler;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*6-1:0]   bin_in;
  logic [5:0]       conv_bin;
  logic [3:0]       conv_tens;
  logic [3:0]       conv_ones;
  logic [N-1:0]     ack;
  logic [N*8-1:0]   bcd_out;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;

  bcd_conv_scheduler #(.NUM_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bin_in    (bin_in),
    .conv_bin  (conv_bin),
    .conv_tens (conv_tens),
    .conv_ones (conv_ones),
    .ack       (ack),
    .bcd_out   (bcd_out),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Shared converter: tens saturates at 5, so 60..63 give ones 10..13.
  always_comb begin
    int t;
    t = (conv_bin >= 6'd50) ? 5 : int'(conv_bin) / 10;
    conv_tens = 4'(t);
    conv_ones = 4'(int'(conv_bin) - t * 10);
  end

  function automatic logic [7:0] ref_bcd(input int v);
    int t;
    t = (v >= 50) ? 5 : v / 10;
    return {4'(t), 4'(v - t * 10)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_bin(input int ch, input int v);
    bin_in[ch*6 +: 6] = 6'(v);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req    = '0;
    bin_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int ch, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack[ch]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no ack on ch%0d within 12 cycles, required ack", name, ch);
    end
  endtask

  function automatic int ack_index(input logic [N-1:0] a);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (a[i]) r = i;
    return r;
  endfunction

  typedef struct {
    int         ch;
    int         val;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  // Randomized-run reference state (transaction level).
  int          m_busy;
  int          m_ch;
  int          m_val;
  int          m_bad;
  int          m_ack;
  int          m_ptr;
  logic [7:0]  m_bcd[N];
  logic [N-1:0] m_exp_ack;
  logic        m_exp_err;

  task automatic model_reset();
    m_busy = 0; m_ch = 0; m_val = 0; m_bad = 0; m_ack = -1; m_ptr = N - 1;
    m_exp_ack = '0; m_exp_err = 1'b0;
    for (int i = 0; i < N; i++) m_bcd[i] = 8'h00;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    m_exp_ack = '0;
    m_exp_err = 1'b0;
    if (m_busy != 0) begin
      if (m_bad != 0) m_exp_err = 1'b1;
      else            m_bcd[m_ch] = ref_bcd(m_val);
      m_exp_ack[m_ch] = 1'b1;
      m_ack  = m_ch;
      m_busy = 0;
    end else begin
      int prev;
      prev  = m_ack;
      m_ack = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req[c] && c != prev) begin
          m_busy = 1;
          m_ch   = c;
          m_ptr  = c;
          m_val  = int'(bin_in[c*6 +: 6]);
`ifdef BCD_RANGE_CHECK_EN
          m_bad  = (m_val > 59) ? 1 : 0;
`else
          m_bad  = 0;
`endif
          break;
        end
      end
    end
  endtask

  function automatic logic [N*8-1:0] model_vec();
    logic [N*8-1:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = m_bcd[i];
    return v;
  endfunction

  initial begin
    logic [N*8-1:0] exp_vec;
    int             order[$];
    int             stamp[$];
    int             first2;
    bit             ok;

    tbl[0] = '{0,  0, 8'h00};
    tbl[1] = '{0, 59, 8'h59};
    tbl[2] = '{0,  9, 8'h09};
    tbl[3] = '{0, 10, 8'h10};
    tbl[4] = '{1, 47, 8'h47};
    tbl[5] = '{2, 23, 8'h23};
    tbl[6] = '{1,  0, 8'h00};
    tbl[7] = '{2, 59, 8'h59};
    tbl[8] = '{1, 19, 8'h19};
    tbl[9] = '{0, 35, 8'h35};

    // Reset state and single-request latency.
    rst = 1'b1; req = '0; bin_in = '0;
    @(negedge clk);
    check("rst_conv_bin", 64'(conv_bin), 64'd0);
    check("rst_bcd",      64'(bcd_out), 64'd0);
    check("rst_ack",      64'(ack), 64'd0);
    check("rst_busy",     64'(busy), 64'd0);
    check("rst_err",      64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    set_bin(1, 47);
    req = 3'b010;
    @(negedge clk);
    check("t1_busy",     64'(busy), 64'd1);
    check("t1_conv_bin", 64'(conv_bin), 64'd47);
    check("t1_no_ack",   64'(ack), 64'd0);
    @(negedge clk);
    check("t1_ack",  64'(ack), 64'(3'b010));
    check("t1_bcd",  64'(bcd_out), 64'h00_47_00);
    check("t1_idle", 64'(busy), 64'd0);
    $display("txn t1 ch=1 bin=47 bcd=%h", bcd_out[15:8]);
    req = '0;
    @(negedge clk);
    check("t1_ack_pulse", 64'(ack), 64'd0);
    check("t1_no_regrant", 64'(busy), 64'd0);

    // Full load: acks in order 0,1,2 every two cycles.
    do_reset();
    set_bin(0, 5); set_bin(1, 30); set_bin(2, 12);
    req = 3'b111;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (ack != '0) begin
        order.push_back(ack_index(ack));
        stamp.push_back(cyc);
        $display("txn t2 ack ch=%0d cycle=%0d", ack_index(ack), cyc);
        req = req & ~ack;
      end
    end
    check("t2_count", 64'(order.size()), 64'd3);
    if (order.size() == 3) begin
      check("t2_order0", 64'(order[0]), 64'd0);
      check("t2_order1", 64'(order[1]), 64'd1);
      check("t2_order2", 64'(order[2]), 64'd2);
      check("t2_gap01", 64'(stamp[1] - stamp[0]), 64'd2);
      check("t2_gap12", 64'(stamp[2] - stamp[1]), 64'd2);
    end
    check("t2_bcd", 64'(bcd_out), 64'h12_30_05);

    // Permanent req[0] must not starve ch2.
    do_reset();
    order.delete();
    first2 = -1;
    set_bin(0, 7); set_bin(2, 44);
    req = 3'b101;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      check("t3_onehot", 64'(($countones(ack) > 1) ? 1 : 0), 64'd0);
      if (ack != '0) begin
        order.push_back(ack_index(ack));
        $display("txn t3 ack ch=%0d cycle=%0d", ack_index(ack), cyc);
      end
      if (ack[2] && first2 < 0) first2 = cyc;
    end
    req = '0;
    check("t3_count_ge4", 64'((order.size() >= 4) ? 1 : 0), 64'd1);
    if (order.size() >= 4) begin
      check("t3_g0", 64'(order[0]), 64'd0);
      check("t3_g1", 64'(order[1]), 64'd2);
      check("t3_g2", 64'(order[2]), 64'd0);
      check("t3_g3", 64'(order[3]), 64'd2);
    end
    check("t3_ch2_latency", 64'((first2 >= 0 && first2 <= 3) ? 1 : 0), 64'd1);

    // Vector table: boundaries and per-channel isolation.
    do_reset();
    exp_vec = '0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      set_bin(tbl[i].ch, tbl[i].val);
      req = '0;
      req[tbl[i].ch] = 1'b1;
      wait_ack(tbl[i].ch, "tbl_ack_timeout", ok);
      exp_vec[tbl[i].ch*8 +: 8] = tbl[i].exp;
      check("tbl_ack", 64'(ack), 64'(1 << tbl[i].ch));
      check("tbl_bcd", 64'(bcd_out), 64'(exp_vec));
      check("tbl_err", 64'(err), 64'd0);
      $display("txn tbl ch=%0d bin=%0d bcd=%h", tbl[i].ch, tbl[i].val, bcd_out[tbl[i].ch*8 +: 8]);
      req = '0;
      @(negedge clk);
    end

    // Out-of-range value on ch0 (ch0 currently holds 8'h35).
    set_bin(0, 60);
    req = 3'b001;
    wait_ack(0, "t5_ack_timeout", ok);
    check("t5_ack", 64'(ack), 64'd1);
`ifdef BCD_RANGE_CHECK_EN
    check("t5_err", 64'(err), 64'd1);
    check("t5_bcd", 64'(bcd_out), 64'(exp_vec));
`else
    exp_vec[7:0] = 8'h5A;
    check("t5_err", 64'(err), 64'd0);
    check("t5_bcd", 64'(bcd_out), 64'(exp_vec));
`endif
    $display("txn t5 ch=0 bin=60 bcd=%h err=%0d", bcd_out[7:0], err);
    req = '0;
    @(negedge clk);
    check("t5_err_pulse", 64'(err), 64'd0);

    // Reset during CONV abandons the conversion; held req is re-granted.
    do_reset();
    set_bin(1, 22);
    req = 3'b010;
    @(negedge clk);
    check("t6_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_ack",      64'(ack), 64'd0);
    check("t6_bcd",      64'(bcd_out), 64'd0);
    check("t6_conv_bin", 64'(conv_bin), 64'd0);
    check("t6_busy_rst", 64'(busy), 64'd0);
    @(negedge clk);
    check("t6_ack_hold", 64'(ack), 64'd0);
    rst = 1'b0;
    wait_ack(1, "t6_regrant_timeout", ok);
    check("t6_bcd_after", 64'(bcd_out), 64'h00_22_00);
    $display("txn t6 ch=1 bin=22 bcd=%h", bcd_out[15:8]);
    req = '0;

    // Randomized traffic against the transaction model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      check("rnd_ack",  64'(ack), 64'(m_exp_ack));
      check("rnd_err",  64'(err), 64'(m_exp_err));
      check("rnd_busy", 64'(busy), 64'(m_busy));
      check("rnd_bcd",  64'(bcd_out), 64'(model_vec()));
      if (m_busy != 0 && m_bad == 0) check("rnd_conv_bin", 64'(conv_bin), 64'(m_val));
      if (ack != '0) $display("txn rnd ack ch=%0d bcd=%h err=%0d", ack_index(ack), bcd_out[ack_index(ack)*8 +: 8], err);
      for (int c = 0; c < N; c++) begin
        if (req[c] && ack[c] && ($urandom % 2 == 0)) req[c] = 1'b0;
        else if (!req[c] && ($urandom % 3 == 0))      req[c] = 1'b1;
        set_bin(c, int'($urandom_range(0, 63)));
      end
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
